// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The execute stage is the master. The divider's HI/LO write port is the slave side.
interface div_if;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_cancel;
    logic        o_busy;
    logic        o_we;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor, i_cancel,
        input  o_busy, o_we, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor, i_cancel,
        output o_busy, o_we, o_hi, o_lo
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 32-bit DIV/DIVU producing one quotient bit per cycle.
// It emits a single HI (remainder) / LO (quotient) write strobe when the result is ready.
module div_unit (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_busy;
    logic        r_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_prev_hi;
    logic [31:0] r_prev_lo;

    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;
    logic        w_kill_done;

    assign w_dvd_mag = (bus.i_signed && bus.i_dividend[31]) ? -bus.i_dividend : bus.i_dividend;
    assign w_dvs_mag = (bus.i_signed && bus.i_divisor[31])  ? -bus.i_divisor  : bus.i_divisor;

    // The shifted partial remainder needs 33 bits. When it is >= divisor, the
    // difference is below 2^32, so a 32-bit subtract is exact.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift[31:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};
    assign w_hi_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_lo_fix  = r_neg_q ? -w_quo_nxt : w_quo_nxt;

    // A flush arriving during DONE must suppress the write it would have made.
    // It also hides the not-yet-committed result.
    assign w_kill_done = (r_state == S_DONE) && bus.i_cancel;
    assign bus.o_busy  = r_busy;
    assign bus.o_we    = r_we & ~bus.i_cancel;
    assign bus.o_hi    = w_kill_done ? r_prev_hi : r_hi;
    assign bus.o_lo    = w_kill_done ? r_prev_lo : r_lo;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_we      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prev_hi <= '0;
            r_prev_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (bus.i_start && !bus.i_cancel) begin
                        r_busy  <= 1'b1;
                        r_neg_q <= bus.i_signed & (bus.i_dividend[31] ^ bus.i_divisor[31]);
                        r_neg_r <= bus.i_signed & bus.i_dividend[31];
                        r_quo   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (bus.i_divisor == 32'd0) begin
                            r_state   <= S_DONE;
                            r_we      <= 1'b1;
                            r_prev_hi <= r_hi;
                            r_prev_lo <= r_lo;
                            r_hi      <= bus.i_dividend;
                            r_lo      <= '1;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    if (bus.i_cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state   <= S_DONE;
                            r_we      <= 1'b1;
                            r_prev_hi <= r_hi;
                            r_prev_lo <= r_lo;
                            r_hi      <= w_hi_fix;
                            r_lo      <= w_lo_fix;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    if (bus.i_cancel) begin
                        r_hi <= r_prev_hi;
                        r_lo <= r_prev_lo;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed and random DIV/DIVU operations checked cycle by cycle
// against an arithmetic reference, plus cancel, reset and ignored-start scenarios.
module tb_div_unit;
    logic clk;
    logic rst;
    div_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    // Reference: plain integer arithmetic (C-style truncating division)
    function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_start    = 1'b0;
        bus.i_cancel   = 1'b0;
        bus.i_signed   = 1'($urandom & 1);
        bus.i_dividend = $urandom;
        bus.i_divisor  = $urandom;
    endtask

    // Issues one operation in the current cycle. It checks idle state, every busy cycle and the
    // DONE cycle, then leaves the bench at the cycle after DONE.
    task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] ehi;
        logic [31:0] elo;
        int lat;
        model(sg, a, b, ehi, elo);
        lat = (b == 32'd0) ? 1 : 33;
        bus.i_start    = 1'b1;
        bus.i_signed   = sg;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_cancel   = 1'b0;
        #2;
        n_cmp++;
        if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b0, 1'b0, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL %s idle: got busy=%b we=%b hi=%h lo=%h, want busy=0 we=0 hi=%h lo=%h",
                     tag, bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, m_hi, m_lo);
        end
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            idle_inputs();
            #2;
            n_cmp++;
            if (k < lat) begin
                if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b1, 1'b0, m_hi, m_lo}) begin
                    n_fail++;
                    $display("FAIL %s T+%0d: got busy=%b we=%b hi=%h lo=%h, want busy=1 we=0 hi=%h lo=%h",
                             tag, k, bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, m_hi, m_lo);
                end
            end else begin
                if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b1, 1'b1, ehi, elo}) begin
                    n_fail++;
                    $display("FAIL %s done T+%0d: got busy=%b we=%b hi=%h lo=%h, want busy=1 we=1 hi=%h lo=%h",
                             tag, k, bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, ehi, elo);
                end
            end
        end
        m_hi = ehi;
        m_lo = elo;
        next_cycle();
        idle_inputs();
    endtask

    // Checks quiet idle behaviour for a number of cycles: no busy, no write, held outputs
    task automatic expect_quiet(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            #2;
            n_cmp++;
            if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b0, 1'b0, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL %s quiet+%0d: got busy=%b we=%b hi=%h lo=%h, want busy=0 we=0 hi=%h lo=%h",
                         tag, k, bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, m_hi, m_lo);
            end
            next_cycle();
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        #2;
        n_cmp++;
        if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b we=%b hi=%h lo=%h, want all zero",
                     bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo);
        end
        next_cycle();
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        expect_quiet(2, "post_reset");
    endtask

    task automatic test_directed();
        do_op(1'b0, 32'd100,       32'd7,         "divu_100_7");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
        do_op(1'b1, 32'd7,         32'hFFFF_FFFE, "div_7_m2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        do_op(1'b0, 32'h1234_5678, 32'd0,         "divu_by_zero");
        do_op(1'b1, 32'h8765_4321, 32'd0,         "div_by_zero");
        do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2");
        do_op(1'b0, 32'd5,         32'd9,         "divu_small");
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 20));
            2:       v = -32'($urandom_range(1, 20));
            3:       v = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          sg;
        for (int n = 0; n < 24; n++) begin
            sg = 1'($urandom & 1);
            a  = pick_operand();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
            do_op(sg, a, b, $sformatf("rand%0d", n));
        end
    endtask

    // Flush (or reset) arriving at T+10 while dividing
    task automatic test_abort(input bit use_rst, input string tag);
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'hDEAD_BEEF;
        bus.i_divisor  = 32'd3;
        #2;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            idle_inputs();
            if (k == 10) begin
                if (use_rst) rst = 1'b1;
                else bus.i_cancel = 1'b1;
            end
            #2;
            n_cmp++;
            if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b1, 1'b0, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL %s T+%0d: got busy=%b we=%b hi=%h lo=%h, want busy=1 we=0 hi=%h lo=%h",
                         tag, k, bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, m_hi, m_lo);
            end
        end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        if (use_rst) begin
            m_hi = '0;
            m_lo = '0;
        end
        expect_quiet(40, tag);
    endtask

    task automatic test_ignore_start();
        logic [31:0] ehi;
        logic [31:0] elo;
        model(1'b0, 32'd1000, 32'd33, ehi, elo);
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'd1000;
        bus.i_divisor  = 32'd33;
        for (int k = 1; k <= 33; k++) begin
            next_cycle();
            idle_inputs();
            if (k == 5) begin
                bus.i_start    = 1'b1;
                bus.i_signed   = 1'b1;
                bus.i_dividend = 32'hFFFF_0000;
                bus.i_divisor  = 32'd0;
            end
            #2;
            if (k == 33) begin
                n_cmp++;
                if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b1, 1'b1, ehi, elo}) begin
                    n_fail++;
                    $display("FAIL ignore_start done: got busy=%b we=%b hi=%h lo=%h, want busy=1 we=1 hi=%h lo=%h",
                             bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, ehi, elo);
                end
            end else begin
                n_cmp++;
                if ({bus.o_busy, bus.o_we} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL ignore_start T+%0d: got busy=%b we=%b, want busy=1 we=0",
                             k, bus.o_busy, bus.o_we);
                end
            end
        end
        m_hi = ehi;
        m_lo = elo;
        next_cycle();
        idle_inputs();
        expect_quiet(1, "ignore_start_after");
    endtask

    task automatic test_start_cancel_idle();
        bus.i_start    = 1'b1;
        bus.i_cancel   = 1'b1;
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'h5555_AAAA;
        bus.i_divisor  = 32'd0;
        #2;
        next_cycle();
        idle_inputs();
        expect_quiet(6, "start_cancel_idle");
    endtask

    task automatic test_cancel_done();
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b1;
        bus.i_dividend = 32'hC000_0001;
        bus.i_divisor  = 32'd5;
        for (int k = 1; k <= 33; k++) begin
            next_cycle();
            idle_inputs();
            if (k == 33) bus.i_cancel = 1'b1;
        end
        #2;
        n_cmp++;
        if ({bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo} !== {1'b1, 1'b0, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL cancel_done T+33: got busy=%b we=%b hi=%h lo=%h, want busy=1 we=0 hi=%h lo=%h",
                     bus.o_busy, bus.o_we, bus.o_hi, bus.o_lo, m_hi, m_lo);
        end
        next_cycle();
        idle_inputs();
        expect_quiet(5, "cancel_done_after");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_random();
        test_abort(1'b0, "cancel_div");
        do_op(1'b0, 32'd77, 32'd10, "after_cancel");
        test_abort(1'b1, "reset_div");
        test_ignore_start();
        test_start_cancel_idle();
        test_cancel_done();
        do_op(1'b1, 32'hFFFF_FF00, 32'd16, "final_op");
        expect_quiet(2, "final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that produces the HI/LO write traffic for the core's HI/LO register. It accepts a DIV/DIVU request from the execute stage, iterates one quotient bit per cycle, then issues a single-cycle write strobe carrying remainder (HI) and quotient (LO). It drives the HI/LO register's write-enable and data inputs directly. It also tells the pipeline to stall while busy.

## Interface
Parameters: none; width fixed at 32 bits.

Clocking and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- i_start  input  1  request; sampled only in IDLE
- i_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with i_start
- i_dividend  input  32  dividend; sampled with i_start
- i_divisor  input  32  divisor; sampled with i_start
- i_cancel  input  1  pipeline flush; aborts any operation in progress
- o_busy  output  1  high while an accepted operation is outstanding
- o_we  output  1  one-cycle write strobe to HI/LO
- o_hi  output  32  remainder
- o_lo  output  32  quotient

## Operation
- States: IDLE, DIV, DONE.
- IDLE:
  - With i_start=1 and i_cancel=0, latch operands and the sign mode.
  - If the divisor is nonzero, go to DIV with the iteration counter at 0.
  - If the divisor is zero, go to DONE directly.
- DIV: restoring radix-2 step on magnitudes.
  - Each step: shift the {rem, quo} pair left 1, trial-subtract |divisor| from the 33-bit partial remainder, and set the quotient LSB to 1 when the result is non-negative.
  - The counter increments each cycle. After the step at counter 31, go to DONE.
- DONE:
  - Assert o_we for exactly that cycle, with o_hi/o_lo valid.
  - Return to IDLE next cycle.
- Signed mode:
  - Operands are converted to magnitudes (two's complement negate if MSB set).
  - Quotient is negated when the dividend sign differs from the divisor sign.
  - Remainder takes the dividend's sign.
  - All results are truncated to 32 bits.
- Overflow: signed 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. This falls out of the truncation rule; no special case.
- Divide by zero (either mode): LO=0xFFFF_FFFF, HI=dividend as given.
- i_start while not in IDLE is ignored. No queuing.
- i_cancel in DIV or DONE: next state is IDLE, o_we stays 0 (it is forced low in the cancel cycle), and o_hi/o_lo keep their previous values.
- i_cancel with i_start in IDLE: cancel wins and the request is dropped.
- o_hi/o_lo update only in the DONE cycle and hold until the next DONE.

## Timing
- Reset values: state IDLE, counter 0, o_busy=0, o_we=0, o_hi=0, o_lo=0, internal operand regs 0.
- Reset mid-operation aborts without a write.
- Normal latency, with i_start sampled at edge T (cycle T):
  - Cycles T+1..T+32: DIV.
  - Cycle T+33: DONE with o_we=1.
  - Cycle T+34: IDLE; a new i_start can be accepted in that cycle.
- Divide-by-zero latency: DONE at T+1, o_we=1 at T+1.
- o_busy is registered and high from T+1 through the DONE cycle inclusive. It is low in IDLE.
- o_we is high for one cycle only and never high in two consecutive cycles.
- Sign fix-up is applied in the DIV to DONE transition. It adds no extra cycle.

## Test plan
- Unsigned 100 / 7, start at T: o_busy high T+1..T+33; at T+33 o_we=1, LO=14, HI=2; o_we=0 at T+34.
- Signed −7 / 2 (0xFFFF_FFF9 / 2): LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Signed 7 / −2: LO=0xFFFF_FFFD, HI=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. Unsigned same operands give LO=0, HI=0x8000_0000.
- Divisor 0, dividend 0x1234_5678, start at T: o_we=1 at T+1, LO=0xFFFF_FFFF, HI=0x1234_5678.
- i_cancel at T+10: IDLE at T+11, o_busy=0 at T+11, no o_we at any later cycle, and o_hi/o_lo unchanged. The same applies to rst at T+10, except outputs go to 0.
- Second i_start at T+5 with other operands is ignored, and the first result arrives at T+33. i_start together with i_cancel in IDLE produces no o_busy and no o_we.
